// File: rtl/byte_register_pkg.sv
// Shared definitions for the byte-wise register family (read and write sides).
package byte_register_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } byte_reg_state_t;

endpackage

// File: rtl/byte_read_register_little_endian.sv
// Serializes a wide register into bytes, least-significant byte first.
// A load is captured in IDLE. The bytes are then handed out one per accepted
// handshake. Every output is decoded from registered state only, so there is
// no combinational path from any input to any output.
module byte_read_register_little_endian
  import byte_register_pkg::*;
#(
  parameter int SIZE_IN_BYTES = 13,
  parameter int BYTE_NUM_SIZE = 4
) (
  input  logic                                CLK,
  input  logic                                ARESET,
  input  logic                                LOAD_VALID,
  output logic                                LOAD_READY,
  input  logic [SIZE_IN_BYTES*BYTE_WIDTH-1:0] LOAD_VALUE,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic [BYTE_WIDTH-1:0]               OUT_BYTE,
  output logic [BYTE_NUM_SIZE-1:0]            OUT_BYTE_NUM,
  output logic                                OUT_LAST
);

  localparam int HOLD_W = SIZE_IN_BYTES * BYTE_WIDTH;
  localparam logic [BYTE_NUM_SIZE-1:0] LAST_IDX = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);

  generate
    if (SIZE_IN_BYTES < 1) begin : g_bad_size
      $error("SIZE_IN_BYTES must be at least 1");
    end
    if ((1 << BYTE_NUM_SIZE) < SIZE_IN_BYTES) begin : g_bad_idx_w
      $error("BYTE_NUM_SIZE too narrow to index SIZE_IN_BYTES bytes");
    end
  endgenerate

  byte_reg_state_t            state;
  byte_reg_state_t            state_nxt;
  logic [BYTE_NUM_SIZE-1:0]   idx;
  logic [BYTE_NUM_SIZE-1:0]   idx_nxt;
  logic [HOLD_W-1:0]          hold;
  logic                       load_fire;

  assign load_fire = (state == IDLE) && LOAD_VALID;

  // Next state and next byte index; LOAD_VALID only matters in IDLE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (LOAD_VALID) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (OUT_READY) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + BYTE_NUM_SIZE'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and index registers; reset abandons any stream in flight.
  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Holding register: written only on the load handshake, frozen during SEND.
  always_ff @(posedge CLK or posedge ARESET) begin
    if (ARESET) begin
      hold <= '0;
    end else if (load_fire) begin
      hold <= LOAD_VALUE;
    end
  end

  // Outputs are gated by state so IDLE always presents zeros.
  assign LOAD_READY   = (state == IDLE);
  assign OUT_VALID    = (state == SEND);
  assign OUT_BYTE     = OUT_VALID ? hold[BYTE_WIDTH*idx +: BYTE_WIDTH] : '0;
  assign OUT_BYTE_NUM = idx;
  assign OUT_LAST     = OUT_VALID && (idx == LAST_IDX);

endmodule

// File: tb/tb_byte_read_register_little_endian.sv
// Bench for byte_read_register_little_endian: a 13-byte instance and a 1-byte
// instance, each checked every cycle against a queue of expected output bytes.
module tb_byte_read_register_little_endian;
  import byte_register_pkg::*;

  localparam int NA = 13;
  localparam int WA = NA * 8;

  logic CLK = 1'b0;
  logic ARESET;
  always #5 CLK = ~CLK;

  // 13-byte instance
  logic          a_load_valid, a_load_ready, a_out_valid, a_out_ready, a_out_last;
  logic [WA-1:0] a_load_value;
  logic [7:0]    a_out_byte;
  logic [3:0]    a_out_byte_num;

  // 1-byte instance
  logic          b_load_valid, b_load_ready, b_out_valid, b_out_ready, b_out_last;
  logic [7:0]    b_load_value;
  logic [7:0]    b_out_byte;
  logic [3:0]    b_out_byte_num;

  byte_read_register_little_endian #(.SIZE_IN_BYTES(NA), .BYTE_NUM_SIZE(4)) u_dut_a (
    .CLK(CLK), .ARESET(ARESET),
    .LOAD_VALID(a_load_valid), .LOAD_READY(a_load_ready), .LOAD_VALUE(a_load_value),
    .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_BYTE(a_out_byte),
    .OUT_BYTE_NUM(a_out_byte_num), .OUT_LAST(a_out_last)
  );

  byte_read_register_little_endian #(.SIZE_IN_BYTES(1), .BYTE_NUM_SIZE(4)) u_dut_b (
    .CLK(CLK), .ARESET(ARESET),
    .LOAD_VALID(b_load_valid), .LOAD_READY(b_load_ready), .LOAD_VALUE(b_load_value),
    .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_BYTE(b_out_byte),
    .OUT_BYTE_NUM(b_out_byte_num), .OUT_LAST(b_out_last)
  );

  // Expected byte stream: what the block still owes downstream, in order.
  typedef struct packed {
    logic [7:0] b;
    logic [3:0] n;
    logic       last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    if (qa.size() == 0) begin
      check_eq("a_load_ready", a_load_ready, 1);
      check_eq("a_out_valid",  a_out_valid, 0);
      check_eq("a_out_byte",   a_out_byte, 0);
      check_eq("a_byte_num",   a_out_byte_num, 0);
      check_eq("a_out_last",   a_out_last, 0);
    end else begin
      check_eq("a_load_ready", a_load_ready, 0);
      check_eq("a_out_valid",  a_out_valid, 1);
      check_eq("a_out_byte",   a_out_byte, qa[0].b);
      check_eq("a_byte_num",   a_out_byte_num, qa[0].n);
      check_eq("a_out_last",   a_out_last, qa[0].last);
    end
  endtask

  task automatic check_b();
    if (qb.size() == 0) begin
      check_eq("b_load_ready", b_load_ready, 1);
      check_eq("b_out_valid",  b_out_valid, 0);
      check_eq("b_out_byte",   b_out_byte, 0);
      check_eq("b_byte_num",   b_out_byte_num, 0);
      check_eq("b_out_last",   b_out_last, 0);
    end else begin
      check_eq("b_load_ready", b_load_ready, 0);
      check_eq("b_out_valid",  b_out_valid, 1);
      check_eq("b_out_byte",   b_out_byte, qb[0].b);
      check_eq("b_byte_num",   b_out_byte_num, qb[0].n);
      check_eq("b_out_last",   b_out_last, qb[0].last);
    end
  endtask

  // One cycle on the 13-byte instance: check, drive, then advance the model.
  task automatic step_a(input logic lv, input logic [WA-1:0] val, input logic rdy);
    @(negedge CLK);
    check_a();
    a_load_valid = lv;
    a_load_value = val;
    a_out_ready  = rdy;
    @(posedge CLK);
    if (qa.size() == 0) begin
      if (lv) begin
        for (int i = 0; i < NA; i++) qa.push_back({val[8*i +: 8], 4'(i), (i == NA - 1)});
      end
    end else if (rdy) begin
      void'(qa.pop_front());
    end
  endtask

  task automatic step_b(input logic lv, input logic [7:0] val, input logic rdy);
    @(negedge CLK);
    check_b();
    b_load_valid = lv;
    b_load_value = val;
    b_out_ready  = rdy;
    @(posedge CLK);
    if (qb.size() == 0) begin
      if (lv) qb.push_back({val, 4'd0, 1'b1});
    end else if (rdy) begin
      void'(qb.pop_front());
    end
  endtask

  task automatic advance_a_to(input int target);
    for (int i = 0; i < 2 * NA && qa.size() != 0 && qa[0].n != 4'(target); i++)
      step_a(1'b0, '0, 1'b1);
    check_eq("a_reached_index", (qa.size() != 0) ? qa[0].n : 4'hF, 4'(target));
  endtask

  task automatic drain_a();
    for (int i = 0; i < 4 * NA && qa.size() != 0; i++) step_a(1'b0, '0, 1'b1);
    check_eq("a_drained", qa.size(), 0);
    step_a(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    ARESET = 1'b1;
    a_load_valid = 1'b0; a_out_ready = 1'b0; a_load_value = '0;
    b_load_valid = 1'b0; b_out_ready = 1'b0; b_load_value = '0;
    #1;
    check_eq("rst_async_out_valid", a_out_valid, 0);
    qa.delete();
    qb.delete();
    repeat (2) @(negedge CLK);
    check_a();
    check_b();
    ARESET = 1'b0;
  endtask

  logic [WA-1:0] val_seq;
  logic [WA-1:0] val_other;
  logic [WA-1:0] val_rand;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    a_load_valid = 1'b0; a_out_ready = 1'b0; a_load_value = '0;
    b_load_valid = 1'b0; b_out_ready = 1'b0; b_load_value = '0;
    for (int i = 0; i < NA; i++) val_seq[8*i +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < NA; i++) val_other[8*i +: 8] = 8'hC0 + 8'(i);

    do_reset();

    // Full stream with OUT_READY held high
    step_a(1'b1, val_seq, 1'b1);
    drain_a();

    // Backpressure at index 5
    step_a(1'b1, val_seq, 1'b1);
    advance_a_to(5);
    repeat (3) step_a(1'b0, '0, 1'b0);
    drain_a();

    // Load offered while busy must be ignored
    step_a(1'b1, val_seq, 1'b1);
    advance_a_to(3);
    step_a(1'b1, val_other, 1'b1);
    drain_a();

    // Reset mid-stream, then a fresh load
    step_a(1'b1, val_seq, 1'b1);
    advance_a_to(7);
    do_reset();
    step_a(1'b1, val_other, 1'b1);
    drain_a();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      val_rand = WA'({$urandom, $urandom, $urandom, $urandom});
      step_a(($urandom_range(0, 3) == 0), val_rand, ($urandom_range(0, 9) < 7));
    end
    a_out_ready = 1'b1;
    drain_a();

    // Single-byte instance
    step_b(1'b1, 8'hA5, 1'b1);
    step_b(1'b0, 8'h00, 1'b1);
    step_b(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 8; c++) step_b(1'b1, 8'($urandom), 1'b1);
    for (int c = 0; c < 30; c++) step_b($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1);
    step_b(1'b0, 8'h00, 1'b1);
    step_b(1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
